data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
Data-memory responder sitting on the RAM side of the CPU memory-access interface: consumes address, write_data, write_strobe and returns read_data. It adds a request/acknowledge handshake and a programmable wait-state counter, so the core can be exercised against slow memory. Writes honour byte-lane strobes; reads always return the full aligned word, and lane selection and extension are left to the memory-access stage. It is instantiated once per core as the data RAM model/controller.

Parameters:
DataWidth, 32, data bus width
AddrWidth, 32, byte-address width
WordSize, 4, bytes per word (strobe width)
ByteBits, 8, bits per byte
Depth, 1024, number of words in the array
WaitCycles, 1, extra wait states before access (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  1  request valid; sampled only when busy=0
write_enable  input  1  1 = write request, 0 = read request
address  input  AddrWidth  byte address; word index = address[AddrWidth-1:2]; bits [1:0] ignored
write_data  input  DataWidth  lane-positioned write data
write_strobe  input  WordSize  byte-lane enables; bit i enables write_data[8i+7:8i]
read_data  output  DataWidth  word read, valid while ack=1, held afterwards
ack  output  1  one-cycle completion pulse
busy  output  1  request in flight; new req ignored
addr_error  output  1  valid with ack; word index >= Depth

Behaviour:
- Reset (async, rst=1): state IDLE, ack=0, busy=0, addr_error=0, read_data=0, counter=0. Memory array is not cleared.
- Reset mid-operation: the pending request is dropped with no ack. A pending write is not performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: busy=0. On an edge with req=1, the block latches write_enable, word index, write_data and write_strobe, loads counter=WaitCycles, and moves to WAIT. Inputs need only be valid on the accepting edge.
- WAIT: busy=1.
  - counter!=0: decrement.
  - counter==0: perform the access on this edge, move to RESP, and register ack=1.
- Access, in range, write: for each i with strobe[i]=1, mem[idx][8i+7:8i] <= data lane i. Unstrobed lanes are unchanged. read_data is unchanged.
- Access, in range, read: read_data <= mem[idx].
- Access, out of range (idx >= Depth): no array write; read_data <= 0 for reads; addr_error <= 1.
- write_enable=1 with strobe=0000 is a legal no-op and still acks.
- RESP: ack=1 and busy=1 for exactly one cycle, then IDLE; ack and addr_error clear to 0. A req present during RESP is ignored and must be re-sampled in IDLE.
- Latency: ack is high in the cycle following edge A+WaitCycles+1, where A is the accepting edge. Minimum request-to-request spacing is WaitCycles+3 cycles.
- read_data holds its last read value until the next read completes.
- Read-after-write to the same word, in consecutive requests, returns the newly written data.

Test Plan:
1. WaitCycles=1; write addr 0x10, data 0xDEADBEEF, strobe 1111 -> ack exactly 2 cycles after acceptance, addr_error=0. Then read 0x10 -> read_data=0xDEADBEEF with ack.
2. Write 0x0000AB00, strobe 0010, addr 0x11 -> subsequent read of 0x10 returns 0xDEADABEF. Then write 0x12340000, strobe 1100 -> read returns 0x1234ABEF.
3. Read addr Depth*4 (0x1000) -> ack with addr_error=1 and read_data=0. Then write 0xFFFFFFFF to 0x1000 followed by a read of 0x0 -> word 0 unchanged.
4. req held high continuously for 10 cycles with WaitCycles=0 -> acks spaced exactly 3 cycles apart, busy=1 between acceptance and end of RESP, no request lost or duplicated.
5. Word 0x20 preloaded 0x11111111; issue a write of 0x22222222 and assert rst during WAIT -> no ack, all outputs return to 0 immediately. A later read of 0x20 returns 0x11111111.
6. Write, strobe 0000, to 0x10 -> ack issued and the word is unchanged. Sweep WaitCycles from 0 to 15 -> ack latency equals WaitCycles+1 in every case.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-addressed RAM behind a req/ack handshake
// with a programmable number of wait states before each access.
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   req             request valid, sampled only while busy=0
//   write_enable    1 = write, 0 = read
//   address         byte address (low two bits ignored)
//   write_data      lane-positioned write data
//   write_strobe    byte-lane enables for writes
//   read_data       full aligned word from the last completed read
//   ack             one-cycle completion pulse
//   busy            request in flight
//   addr_error      with ack: word index was beyond the array
module data_memory_responder #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int WordSize   = 4,
  parameter int ByteBits   = 8,
  parameter int Depth      = 1024,
  parameter int WaitCycles = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 write_enable,
  input  logic [AddrWidth-1:0] address,
  input  logic [DataWidth-1:0] write_data,
  input  logic [WordSize-1:0]  write_strobe,
  output logic [DataWidth-1:0] read_data,
  output logic                 ack,
  output logic                 busy,
  output logic                 addr_error
);

  localparam int OffW = $clog2(WordSize);
  localparam int IdxW = AddrWidth - OffW;
  localparam int MemW = $clog2(Depth);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [WordSize-1:0]  strb_q, strb_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 aerr_q, aerr_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic [DataWidth-1:0] mem [Depth];

  logic            in_range;
  logic [MemW-1:0] mem_addr;
  logic            access;
  logic            mem_we;
  logic            unused_addr;

  assign unused_addr = ^address[OffW-1:0];

  assign in_range = idx_q < IdxW'(Depth);
  assign mem_addr = idx_q[MemW-1:0];
  // Access edge: last wait state has elapsed.
  assign access   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we   = access && we_q && in_range;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    aerr_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = write_enable;
          idx_d   = address[AddrWidth-1:OffW];
          wdata_d = write_data;
          strb_d  = write_strobe;
          cnt_d   = 4'(WaitCycles);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          ack_d   = 1'b1;
          aerr_d  = !in_range;
          if (!we_q) begin
            rdata_d = in_range ? mem[mem_addr] : '0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      aerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      aerr_q  <= aerr_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is deliberately not reset; reset forces IDLE so a
  // pending write can never reach this port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < WordSize; i++) begin
        if (strb_q[i]) begin
          mem[mem_addr][i*ByteBits +: ByteBits] <=
            wdata_q[i*ByteBits +: ByteBits];
        end
      end
    end
  end

  assign read_data  = rdata_q;
  assign ack        = ack_q;
  assign busy       = (state_q != IDLE);
  assign addr_error = aerr_q;

endmodule
